// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

    // Controller operating modes: normal issue, HALT drain, and stopped.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Cycles a HALT needs to travel from ID to WB.
    localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_hazard_detect.sv
// Combinational RAW hazard check of the ID source registers against the
// destination registers held in the three downstream pipeline latches.
// The register file does not bypass, so a write still sitting in MEM/WB
// is a hazard too. Register 0 is treated like any other register.
module raw_hazard_detect #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic                  id_rs_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_rt_valid_i,
    input  logic [REG_ADDR_W-1:0] idex_wreg_i,
    input  logic                  idex_regwrite_i,
    input  logic [REG_ADDR_W-1:0] exmem_wreg_i,
    input  logic                  exmem_regwrite_i,
    input  logic [REG_ADDR_W-1:0] memwb_wreg_i,
    input  logic                  memwb_regwrite_i,
    output logic                  raw_hz_o
);

    logic rs_hz;
    logic rt_hz;

    // A source conflicts when it is read and any writing latch targets it.
    always_comb begin
        rs_hz = id_rs_valid_i &&
                ((idex_regwrite_i  && (id_rs_i == idex_wreg_i))  ||
                 (exmem_regwrite_i && (id_rs_i == exmem_wreg_i)) ||
                 (memwb_regwrite_i && (id_rs_i == memwb_wreg_i)));
        rt_hz = id_rt_valid_i &&
                ((idex_regwrite_i  && (id_rt_i == idex_wreg_i))  ||
                 (exmem_regwrite_i && (id_rt_i == exmem_wreg_i)) ||
                 (memwb_regwrite_i && (id_rt_i == memwb_wreg_i)));
        raw_hz_o = rs_hz || rt_hz;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage, non-forwarding pipeline.
// Enables, flushes and bubbles are combinational from state and inputs;
// halted_o and the stall-cycle counter are registered.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic                  id_rs_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_rt_valid_i,
    input  logic [REG_ADDR_W-1:0] idex_wreg_i,
    input  logic [REG_ADDR_W-1:0] exmem_wreg_i,
    input  logic [REG_ADDR_W-1:0] memwb_wreg_i,
    input  logic                  idex_regwrite_i,
    input  logic                  exmem_regwrite_i,
    input  logic                  memwb_regwrite_i,
    input  logic                  ex_redirect_i,
    input  logic                  halt_id_i,
    input  logic                  mem_stall_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_en_o,
    output logic                  idex_bubble_o,
    output logic                  exmem_en_o,
    output logic                  memwb_en_o,
    output logic                  halted_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

    state_e           state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             raw_hz;

    raw_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_raw_hazard_detect (
        .id_rs_i          (id_rs_i),
        .id_rs_valid_i    (id_rs_valid_i),
        .id_rt_i          (id_rt_i),
        .id_rt_valid_i    (id_rt_valid_i),
        .idex_wreg_i      (idex_wreg_i),
        .idex_regwrite_i  (idex_regwrite_i),
        .exmem_wreg_i     (exmem_wreg_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .memwb_wreg_i     (memwb_wreg_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .raw_hz_o         (raw_hz)
    );

    // Next-state and enable decode; priority mem_stall > redirect > RAW > HALT.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_en_o     = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_en_o    = 1'b0;
        memwb_en_o    = 1'b0;
        if (!rst && !mem_stall_i) begin
            case (state_q)
                ST_RUN: begin
                    idex_en_o  = 1'b1;
                    exmem_en_o = 1'b1;
                    memwb_en_o = 1'b1;
                    if (ex_redirect_i) begin
                        pc_en_o       = 1'b1;
                        ifid_en_o     = 1'b1;
                        ifid_flush_o  = 1'b1;
                        idex_bubble_o = 1'b1;
                    end else if (raw_hz) begin
                        idex_bubble_o = 1'b1;
                    end else if (halt_id_i) begin
                        ifid_en_o    = 1'b1;
                        ifid_flush_o = 1'b1;
                        state_d      = ST_DRAIN;
                        drain_cnt_d  = DCW'(DRAIN_CYCLES);
                    end else begin
                        pc_en_o   = 1'b1;
                        ifid_en_o = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ifid_en_o    = 1'b1;
                    ifid_flush_o = 1'b1;
                    idex_en_o    = 1'b1;
                    exmem_en_o   = 1'b1;
                    memwb_en_o   = 1'b1;
                    if (drain_cnt_q <= DCW'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = ST_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DCW'(1);
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Registered status: halted flag and saturating count of cycles without PC progress.
    always_comb begin
        halted_d    = (state_d == ST_HALTED);
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted_o       = halted_q;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. Each driven cycle pushes its
// expected enables/status; a monitor pops and compares mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW = 3;
    localparam int unsigned CW = 5;

    // Enable vector order: {pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb}
    localparam logic [6:0] EN_NORM  = 7'b1101011;
    localparam logic [6:0] EN_RAW   = 7'b0001111;
    localparam logic [6:0] EN_REDIR = 7'b1111111;
    localparam logic [6:0] EN_HALT  = 7'b0111011;
    localparam logic [6:0] EN_ZERO  = 7'b0000000;

    typedef struct {
        string      tag;
        logic [6:0] en;
        logic       halted;
        int         cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, idex_wreg, exmem_wreg, memwb_wreg;
    logic          id_rs_valid, id_rt_valid;
    logic          idex_rw, exmem_rw, memwb_rw;
    logic          ex_redirect, halt_id, mem_stall;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
    logic          halted;
    logic [CW-1:0] stall_cycles;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (RW),
        .DRAIN_CYCLES (3),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs_i          (id_rs),
        .id_rs_valid_i    (id_rs_valid),
        .id_rt_i          (id_rt),
        .id_rt_valid_i    (id_rt_valid),
        .idex_wreg_i      (idex_wreg),
        .exmem_wreg_i     (exmem_wreg),
        .memwb_wreg_i     (memwb_wreg),
        .idex_regwrite_i  (idex_rw),
        .exmem_regwrite_i (exmem_rw),
        .memwb_regwrite_i (memwb_rw),
        .ex_redirect_i    (ex_redirect),
        .halt_id_i        (halt_id),
        .mem_stall_i      (mem_stall),
        .pc_en_o          (pc_en),
        .ifid_en_o        (ifid_en),
        .ifid_flush_o     (ifid_flush),
        .idex_en_o        (idex_en),
        .idex_bubble_o    (idex_bubble),
        .exmem_en_o       (exmem_en),
        .memwb_en_o       (memwb_en),
        .halted_o         (halted),
        .stall_cycles_o   (stall_cycles)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected outputs.
    task automatic applyStimulus(input string tag, input logic r,
                                 input logic rsv, input int rs, input logic rtv, input int rt,
                                 input logic irw, input int iw, input logic erw, input int ew,
                                 input logic wrw, input int ww,
                                 input logic redir, input logic hlt, input logic stl,
                                 input logic [6:0] en, input logic hl, input int cnt);
        exp_t e;
        @(negedge clk);
        rst         = r;
        id_rs_valid = rsv;  id_rs      = RW'(rs);
        id_rt_valid = rtv;  id_rt      = RW'(rt);
        idex_rw     = irw;  idex_wreg  = RW'(iw);
        exmem_rw    = erw;  exmem_wreg = RW'(ew);
        memwb_rw    = wrw;  memwb_wreg = RW'(ww);
        ex_redirect = redir;
        halt_id     = hlt;
        mem_stall   = stl;
        e.tag = tag; e.en = en; e.halted = hl; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: sample 2 time units after the falling edge, well before the rising edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, ".en"},
                        32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}),
                        32'(e.en));
            checkOutput({e.tag, ".halted"}, 32'(halted), 32'(e.halted));
            checkOutput({e.tag, ".stall"}, 32'(stall_cycles), 32'(e.cnt));
        end
    end

    initial begin
        int sat;
        rst = 1'b1;
        id_rs = '0; id_rt = '0; idex_wreg = '0; exmem_wreg = '0; memwb_wreg = '0;
        id_rs_valid = 1'b0; id_rt_valid = 1'b0;
        idex_rw = 1'b0; exmem_rw = 1'b0; memwb_rw = 1'b0;
        ex_redirect = 1'b0; halt_id = 1'b0; mem_stall = 1'b0;

        // Reset: first cycle unchecked (registers not yet loaded), second checked.
        @(negedge clk);
        applyStimulus("rst", 1, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_ZERO, 0, 0);

        // No hazards for 10 cycles.
        for (int i = 0; i < 10; i++)
            applyStimulus("norm", 0, 1,1,1,2, 0,0,0,0,0,0, 0,0,0, EN_NORM, 0, 0);

        // r3 producer walking ID/EX -> EX/MEM -> MEM/WB.
        applyStimulus("raw_idex",  0, 1,3,0,0, 1,3,0,0,0,0, 0,0,0, EN_RAW, 0, 0);
        applyStimulus("raw_exmem", 0, 1,3,0,0, 0,0,1,3,0,0, 0,0,0, EN_RAW, 0, 1);
        applyStimulus("raw_memwb", 0, 1,3,0,0, 0,0,0,0,1,3, 0,0,0, EN_RAW, 0, 2);
        applyStimulus("raw_clear", 0, 1,3,0,0, 0,0,0,0,0,0, 0,0,0, EN_NORM, 0, 3);
        // rt source, invalid source, no regwrite, register 0.
        applyStimulus("raw_rt",    0, 0,0,1,5, 0,0,1,5,0,0, 0,0,0, EN_RAW, 0, 3);
        applyStimulus("rt_novld",  0, 0,0,0,5, 0,0,1,5,0,0, 0,0,0, EN_NORM, 0, 4);
        applyStimulus("no_rw",     0, 1,6,1,6, 0,6,0,6,0,6, 0,0,0, EN_NORM, 0, 4);
        applyStimulus("raw_r0",    0, 1,0,0,0, 0,0,0,0,1,0, 0,0,0, EN_RAW, 0, 4);

        // Redirect beats RAW and HALT; counter unchanged.
        applyStimulus("redir_raw", 0, 1,3,0,0, 1,3,0,0,0,0, 1,0,0, EN_REDIR, 0, 5);
        applyStimulus("redir_hlt", 0, 0,0,0,0, 0,0,0,0,0,0, 1,1,0, EN_REDIR, 0, 5);

        // Memory stall with redirect held for 4 cycles, then the flush.
        for (int i = 0; i < 4; i++)
            applyStimulus("mstall", 0, 0,0,0,0, 0,0,0,0,0,0, 1,0,1, EN_ZERO, 0, 5 + i);
        applyStimulus("mstall_rd", 0, 0,0,0,0, 0,0,0,0,0,0, 1,0,0, EN_REDIR, 0, 9);

        // HALT: drain with a stall in the second drain cycle; redirect/RAW ignored.
        applyStimulus("halt_id", 0, 0,0,0,0, 0,0,0,0,0,0, 0,1,0, EN_HALT, 0, 9);
        applyStimulus("drain1",  0, 1,3,0,0, 1,3,0,0,0,0, 1,0,0, EN_HALT, 0, 10);
        applyStimulus("drain_st",0, 0,0,0,0, 0,0,0,0,0,0, 0,0,1, EN_ZERO, 0, 11);
        applyStimulus("drain2",  0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_HALT, 0, 12);
        applyStimulus("drain3",  0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_HALT, 0, 13);
        applyStimulus("halted1", 0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_ZERO, 1, 14);
        applyStimulus("halted2", 0, 0,0,0,0, 0,0,0,0,0,0, 1,1,0, EN_ZERO, 1, 15);

        // Reset out of HALTED, then normal operation resumes.
        applyStimulus("hrst",    1, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_ZERO, 1, 16);
        applyStimulus("post_rst",0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_NORM, 0, 0);

        // Second HALT, then idle in HALTED long enough to saturate the counter.
        applyStimulus("halt2",   0, 0,0,0,0, 0,0,0,0,0,0, 0,1,0, EN_HALT, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("drain_b", 0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_HALT, 0, 1 + i);
        for (int k = 0; k < 35; k++) begin
            sat = (4 + k > 31) ? 31 : 4 + k;
            applyStimulus("sat", 0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, EN_ZERO, 1, sat);
        end

        // Let the monitor consume the last entry, then confirm the queue drained.
        @(negedge clk);
        #4;
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches); the pipeline has no forwarding.
- Drives the PC and per-latch write enables, flushes and bubbles.
- Detects RAW hazards against the three downstream destination registers.
- Freezes the pipeline on memory stalls and squashes wrong-path instructions on taken branch/jump.
- Sequences HALT: a drain FSM empties the pipe, then the core stops.
- Keeps a saturating stall-cycle counter.

Parameters:
REG_ADDR_W, 3, register specifier width
DRAIN_CYCLES, 3, cycles for HALT to travel ID->WB
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_rs_i  in  REG_ADDR_W  ID-stage source register 1
id_rs_valid_i  in  1  ID instruction reads rs
id_rt_i  in  REG_ADDR_W  ID-stage source register 2
id_rt_valid_i  in  1  ID instruction reads rt
idex_wreg_i / exmem_wreg_i / memwb_wreg_i  in  REG_ADDR_W each  destination reg held in each latch
idex_regwrite_i / exmem_regwrite_i / memwb_regwrite_i  in  1 each  RegWrite held in each latch
ex_redirect_i  in  1  branch taken or jump resolved in EX
halt_id_i  in  1  HALT instruction in ID
mem_stall_i  in  1  instruction or data memory not ready
pc_en_o  out  1  PC write enable
ifid_en_o  out  1  IF/ID enable
ifid_flush_o  out  1  load NOP into IF/ID
idex_en_o  out  1  ID/EX enable
idex_bubble_o  out  1  load NOP (all control 0) into ID/EX
exmem_en_o  out  1  EX/MEM enable
memwb_en_o  out  1  MEM/WB enable
halted_o  out  1  core halted, registered
stall_cycles_o  out  CNT_W  saturating count of non-RUN-progress cycles

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset -> RUN, drain_cnt=0, halted_o=0, stall_cycles_o=0.
- While rst=1, all enables, flush and bubble outputs are 0.
- raw_hz = any source (valid) equal to a latch wreg whose regwrite=1, checked against ID/EX, EX/MEM and MEM/WB. The register file does not bypass, so MEM/WB counts. Register 0 is not special.
- Priority, highest first: mem_stall > ex_redirect > raw_hz > halt_id > normal.
- mem_stall_i=1, any state:
  - All enables 0; flush and bubble 0.
  - drain_cnt is frozen.
  - Any pending redirect remains asserted by EX and is acted on when the stall clears.
- RUN, redirect:
  - pc_en=1 (PC loads target).
  - ifid_en=1 with ifid_flush=1; idex_en=1 with idex_bubble=1.
  - exmem_en=1, memwb_en=1.
  - halt_id and raw_hz are ignored (wrong path).
- RUN, raw_hz:
  - pc_en=0, ifid_en=0.
  - idex_en=1 with idex_bubble=1.
  - exmem_en=1, memwb_en=1.
  - Repeats each cycle until the hazard clears.
- RUN, halt_id:
  - pc_en=0.
  - ifid_en=1 with ifid_flush=1.
  - idex, exmem, memwb enabled.
  - Next state DRAIN, drain_cnt=DRAIN_CYCLES.
- RUN, none of the above: all enables 1; flush and bubble 0.
- DRAIN:
  - pc_en=0; ifid_en=1 with ifid_flush=1.
  - Other latches enabled.
  - drain_cnt decrements each non-stalled cycle; when it reaches 0, next state HALTED.
  - Redirect and raw_hz cannot occur; if asserted they are ignored.
- HALTED: all enables 0, halted_o=1; held until rst.
- stall_cycles_o increments by 1 in any cycle where rst=0 and pc_en_o=0, including DRAIN and HALTED. It saturates at all-ones and never wraps.
- Output registration:
  - All enable, flush and bubble outputs are combinational from state and inputs; zero-latency response.
  - halted_o and stall_cycles_o are registered.

Decomposition:
- Shared package: state enum (RUN/DRAIN/HALTED) and DRAIN_CYCLES default.
- One natural sub-module: raw_hazard_detect, combinational compare of rs/rt against the three latch destinations.
- FSM, counters and enable logic stay in the top module.

Test Plan:
- No hazards for 10 cycles: all enables 1 every cycle; stall_cycles_o=0.
- ID reads r3 (rs_valid=1), ID/EX wreg=3, regwrite=1, register advancing through EX/MEM and MEM/WB on the following cycles: pc_en=0 and idex_bubble=1 for exactly 3 cycles, then normal; stall_cycles_o=3.
- ex_redirect=1 together with raw_hz=1: ifid_flush=1, idex_bubble=1, pc_en=1; stall counter unchanged.
- mem_stall=1 for 4 cycles with ex_redirect=1 held: all enables 0 for 4 cycles; redirect flush occurs on the 5th cycle.
- halt_id=1 in RUN:
  - 3 DRAIN cycles with pc_en=0.
  - mem_stall in the second DRAIN cycle extends the drain by 1.
  - halted_o=1 thereafter; enables 0.
- In HALTED assert rst for 1 cycle: state RUN, halted_o=0, stall_cycles_o=0, enables 1 next cycle.
